hopfield_trainer: RTL
=====================

// Module: hopfield_trainer
// PURPOSE
//  Upstream stage of the Hopfield recall array. Collects up to NPAT binary
//  NN-bit training patterns over a valid/ready port. On start, it computes the
//  Hebbian weight matrix w[k][m] = sum_p (p[k]==p[m] ? +1 : -1) and streams it,
//  one entry per clock, into the recall stage's link memory (addr = k*NN+m).
//  Replaces the one-shot parallel weight load with a sequential, handshaked writer.
// PARAMETERS
//  NN    25  neurons per pattern (5x5 matrix); weight count NN*NN
//  NPAT  5   max stored patterns; must satisfy NPAT <= 2**(WW-1)-1
//  WW    4   signed weight width on wr_data
//  AW    $clog2(NN*NN) (localparam, 10 at default)  write address width
// PORTS
//  clk        in   1     system clock, all logic on rising edge
//  rst        in   1     asynchronous reset, active-low
//  pat_valid  in   1     pat_data holds a pattern to store
//  pat_ready  out  1     pattern slot free and block idle
//  pat_data   in   NN    training pattern, bit i = neuron i
//  clear      in   1     1-cycle pulse: discard all stored patterns
//  start      in   1     1-cycle pulse: compute and stream weights
//  busy       out  1     weight stream in progress
//  done       out  1     1-cycle pulse after the last weight is written
//  wr_en      out  1     weight write strobe
//  wr_addr    out  AW    weight index k*NN+m
//  wr_data    out  WW    signed weight, two's complement
//  pat_count  out  $clog2(NPAT+1)  number of patterns stored
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; pat_count=0; busy, done, wr_en = 0;
//    wr_addr=0; wr_data=0. Stored pattern contents are don't-care.
//  - pat_ready = (state==IDLE) && (pat_count<NPAT) && !clear.
//  - Handshake pat_valid&&pat_ready stores pat_data in slot pat_count; pat_count+1 next edge.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//    IDLE: start=1 -> CALC; indices k=m=0.
//    CALC: each cycle emits one weight with wr_en=1. m increments; on
//      m=NN-1, m wraps to 0 and k increments. After k=m=NN-1 -> DONE.
//    DONE: done=1 for exactly 1 cycle, wr_en=0 -> IDLE.
//  - Outputs are registered. Start sampled at edge 0 gives wr_en high for
//    cycles 1..NN*NN (625), with addr 0..624 ascending and no gaps. done is
//    high in cycle 626. busy = (state!=IDLE), high in cycles 1..626.
//  - Weight arithmetic: matches = popcount over slots j<pat_count of
//    ~(p_j[k]^p_j[m]); wr_data = 2*matches - pat_count. Slots >= pat_count
//    are ignored. Range is +-NPAT, so the result never saturates.
//  - Same-cycle events in IDLE:
//    clear + start -> clear wins; start is ignored.
//    clear + pat_valid -> pattern is not accepted; pat_count goes to 0.
//    start + accepted pattern -> the pattern is included in the calculation.
//  - start, clear and pat_valid are ignored while busy.
//  - start with pat_count=0 is legal: 625 writes of 0, then done.
//  - Reset mid-CALC aborts immediately; there are no further writes.
//    The downstream link memory is left partially written.
// CONFIGURATION
//  HOPFIELD_ZERO_DIAG_EN: when defined, entries with k==m are written as 0.
//    Undefined (default): the diagonal is written as +pat_count, per the
//    formula. The write count and timing are identical either way.
// STRUCTURE
//  - hopfield_pkg holds shared definitions:
//    localparams NN, NPAT, WW;
//    typedef weight_t (signed [WW-1:0]);
//    typedef pattern_t ([NN-1:0]);
//    enum trn_state_t {IDLE, CALC, DONE}.
//    The recall stage imports the same package.
//  - One sub-module, hopfield_hebb_term, is combinational. It takes
//    (patterns, pat_count, k, m) and returns weight_t; it is reusable for
//    on-line learning.
// TESTING
//  1. Load D=25'h0E94A4F only, then start. Check w[0][1]=+1 (addr 1),
//     w[0][4]=-1 (addr 4), w[0][0]=+1, exactly 625 wr_en cycles, and done at
//     start+626.
//  2. Load D,C,J,M,D (5 patterns). Assert pat_valid a 6th time: pat_ready=0
//     and pat_count stays 5. After start, every diagonal entry = +5 and all
//     |wr_data| <= 5.
//  3. Start with 0 patterns -> 625 writes of 0, then done. busy is high for
//     626 cycles.
//  4. Pull rst low asynchronously at write #300 (addr 299): wr_en, busy and
//     done drop at once. After release, pat_count=0 and pat_ready=1.
//  5. Start/clear/pat_valid during CALC are ignored (count is unchanged).
//     Same-cycle clear+pat_valid in IDLE gives pat_count=0.
//  6. Build with HOPFIELD_ZERO_DIAG_EN, re-run test 2: addr 0, 26, ..., 624
//     are 0; all other entries match the non-macro run.

Source files
------------

// File: rtl/hopfield_pkg.sv
// Shared definitions for the Hopfield trainer and recall stages.
package hopfield_pkg;

    localparam int NN   = 25;
    localparam int NPAT = 5;
    localparam int WW   = 4;
    localparam int AW   = $clog2(NN * NN);
    localparam int CW   = $clog2(NPAT + 1);
    localparam int KW   = $clog2(NN);

    typedef logic signed [WW-1:0] weight_t;
    typedef logic [NN-1:0]        pattern_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } trn_state_t;

endpackage

// File: rtl/hopfield_hebb_term.sv
// Combinational Hebbian term for one (k,m) pair over the first i_count stored patterns.
module hopfield_hebb_term
    import hopfield_pkg::*;
(
    input  logic [NPAT*NN-1:0] i_pats,
    input  logic [CW-1:0]      i_count,
    input  logic [KW-1:0]      i_k,
    input  logic [KW-1:0]      i_m,
    output logic [WW-1:0]      o_weight
);

    logic [NPAT-1:0] w_eq;
    logic [CW-1:0]   w_matches;

    for (genvar g = 0; g < NPAT; g++) begin : g_slot
        pattern_t w_pat;
        assign w_pat   = i_pats[g*NN +: NN];
        assign w_eq[g] = (w_pat[i_k] == w_pat[i_m]) && (CW'(g) < i_count);
    end

    // Each stored pattern contributes +1 on agreement and -1 otherwise.
    assign w_matches = CW'($countones(w_eq));
    assign o_weight  = WW'(w_matches) + WW'(w_matches) - WW'(i_count);

endmodule

// File: rtl/hopfield_trainer.sv
// Collects training patterns and streams the Hebbian weight matrix, one entry per clock.
// Build option: HOPFIELD_ZERO_DIAG_EN forces the k==m entries to zero.
module hopfield_trainer
    import hopfield_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          pat_valid,
    output logic          pat_ready,
    input  logic [NN-1:0] pat_data,
    input  logic          clear,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [WW-1:0] wr_data,
    output logic [CW-1:0] pat_count
);

    trn_state_t         r_state;
    logic [NPAT*NN-1:0] r_pats;
    logic [CW-1:0]      r_count;
    logic [KW-1:0]      r_k;
    logic [KW-1:0]      r_m;
    logic [AW-1:0]      r_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_wr_en;
    logic [AW-1:0]      r_wr_addr;
    logic [WW-1:0]      r_wr_data;

    logic               w_accept;
    logic [WW-1:0]      w_term;
    logic [WW-1:0]      w_wdata;

    assign pat_ready = (r_state == IDLE) && (r_count < CW'(NPAT)) && !clear;
    assign w_accept  = pat_valid && pat_ready;

    hopfield_hebb_term u_term (
        .i_pats   (r_pats),
        .i_count  (r_count),
        .i_k      (r_k),
        .i_m      (r_m),
        .o_weight (w_term)
    );

`ifdef HOPFIELD_ZERO_DIAG_EN
    assign w_wdata = (r_k == r_m) ? '0 : w_term;
`else
    assign w_wdata = w_term;
`endif

    // Pattern contents need no reset; only slots below r_count are ever used.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NPAT; j++) begin
            if (w_accept && (r_count == CW'(j))) begin
                r_pats[j*NN +: NN] <= pat_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_k       <= '0;
            r_m       <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear) begin
                        r_count <= '0;
                    end else begin
                        if (w_accept) begin
                            r_count <= r_count + CW'(1);
                        end
                        if (start) begin
                            r_state <= CALC;
                            r_k     <= '0;
                            r_m     <= '0;
                            r_idx   <= '0;
                        end
                    end
                end
                CALC: begin
                    r_busy    <= 1'b1;
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_idx;
                    r_wr_data <= w_wdata;
                    r_idx     <= r_idx + AW'(1);
                    if (r_m == KW'(NN - 1)) begin
                        r_m <= '0;
                        if (r_k == KW'(NN - 1)) begin
                            r_state <= DONE;
                        end else begin
                            r_k <= r_k + KW'(1);
                        end
                    end else begin
                        r_m <= r_m + KW'(1);
                    end
                end
                DONE: begin
                    // Held for two cycles so busy covers the done pulse.
                    if (!r_done) begin
                        r_done  <= 1'b1;
                        r_wr_en <= 1'b0;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign pat_count = r_count;

endmodule
